// File: rtl/weight_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | weight_sequencer                                                       |
// | Loads one neuron's weights from the tagged config stream into its RAM, |
// | then streams RAM reads in lock-step with the input samples for the MAC.|
// | Optional: WSEQ_PRETRAINED_EN (weights preloaded, config load removed). |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module weight_sequencer #(
  parameter int NUM_WEIGHT = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [31:0]           cfg_layer,
  input  logic [31:0]           cfg_neuron,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  mac_valid,
  output logic [DATA_WIDTH-1:0] mac_x,
  output logic                  mac_last,
  output logic                  loaded,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   load_cnt_q, load_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    loaded_q, loaded_d;
  logic                    mac_valid_q, mac_valid_d;
  logic [DATA_WIDTH-1:0]   mac_x_q, mac_x_d;
  logic                    mac_last_q, mac_last_d;
  logic                    cfg_match;
  logic                    accept;

`ifdef WSEQ_PRETRAINED_EN
  localparam state_t RESET_STATE = ST_RUN;
  logic unused_cfg;
  assign unused_cfg = ^{cfg_valid, cfg_layer, cfg_neuron, cfg_data};
  assign cfg_match  = 1'b0;
`else
  localparam state_t RESET_STATE = ST_LOAD;
  assign cfg_match = cfg_valid && (cfg_layer == 32'(LAYER_NO))
                               && (cfg_neuron == 32'(NEURON_NO));
`endif

  // loaded_q lags the RUN entry by one cycle, so it also gates input acceptance
  assign accept = in_valid && loaded_q;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    loaded_d    = (state_q == ST_RUN);
    mac_valid_d = accept;
    mac_x_d     = accept ? in_data : mac_x_q;
    mac_last_d  = accept && (rd_cnt_q == LAST_IDX);

    case (state_q)
      ST_LOAD: begin
        if (cfg_match) begin
          wr_en_d   = 1'b1;
          wr_addr_d = load_cnt_q;
          wr_data_d = cfg_data;
          if (load_cnt_q == LAST_IDX) begin
            load_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            load_cnt_d = load_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          rd_cnt_d = (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      load_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      loaded_q    <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_x_q     <= '0;
      mac_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      loaded_q    <= loaded_d;
      mac_valid_q <= mac_valid_d;
      mac_x_q     <= mac_x_d;
      mac_last_q  <= mac_last_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign in_ready  = loaded_q;
  assign rd_en     = accept;
  assign rd_addr   = rd_cnt_q;
  assign mac_valid = mac_valid_q;
  assign mac_x     = mac_x_q;
  assign mac_last  = mac_last_q;
  assign loaded    = loaded_q;
  assign busy      = (rd_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_weight_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_weight_sequencer                                                    |
// | Directed + randomized bench with a weight-RAM model and a ref model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_weight_sequencer;

  localparam int NUM_WEIGHT = 3;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 16;
  localparam int LAYER_NO   = 1;
  localparam int NEURON_NO  = 0;
`ifdef WSEQ_PRETRAINED_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_valid;
  logic [31:0]           cfg_layer, cfg_neuron;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready, rd_en, mac_valid, mac_last, loaded, busy;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mac_x;

  weight_sequencer #(
    .NUM_WEIGHT(NUM_WEIGHT), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .LAYER_NO(LAYER_NO), .NEURON_NO(NEURON_NO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .mac_valid(mac_valid), .mac_x(mac_x), .mac_last(mac_last),
    .loaded(loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  // Weight RAM with one-cycle read latency; contents survive reset
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data;
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    if (rd_en) rd_data <= ram[rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counts of weights loaded and of elements accepted
  logic [DATA_WIDTH-1:0] m_w [NUM_WEIGHT];
  bit   m_init = 0;
  bit   m_done = 0;
  bit   exp_loaded = 0;
  int   m_nw = 0;
  int   m_acc = 0;
  bit   e_rst, e_wr_en, e_mv, e_ml;
  int   e_wr_addr;
  logic [DATA_WIDTH-1:0] e_wr_data, e_mx, e_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit acc, match;
    #1;
    if (m_init) begin
      chk("in_ready", in_ready, exp_loaded);
      chk("rd_en", rd_en, in_valid && exp_loaded);
      if (in_valid && exp_loaded) chk("rd_addr", rd_addr, m_acc);
      chk("busy", busy, m_acc != 0);
    end
    e_rst = !rst_n;
    if (!rst_n) begin
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = '0;
      e_mv = 0; e_mx = '0; e_ml = 0;
      exp_loaded = 0; m_nw = 0; m_acc = 0; m_done = PRE;
    end else begin
      acc   = in_valid && exp_loaded;
      match = !PRE && !m_done && cfg_valid &&
              cfg_layer == LAYER_NO && cfg_neuron == NEURON_NO;
      exp_loaded = m_done;
      e_wr_en = match;
      if (match) begin
        e_wr_addr = m_nw; e_wr_data = cfg_data; m_w[m_nw] = cfg_data;
        m_nw++;
        if (m_nw == NUM_WEIGHT) begin m_done = 1; m_nw = 0; end
      end
      e_mv = acc;
      e_ml = acc && (m_acc == NUM_WEIGHT - 1);
      if (acc) begin
        e_mx = in_data; e_w = m_w[m_acc];
        m_acc = (m_acc + 1) % NUM_WEIGHT;
      end
    end
    @(posedge clk);
    #1;
    if (e_rst) m_init = 1;
    chk("wr_en", wr_en, e_wr_en);
    if (e_wr_en || e_rst) begin
      chk("wr_addr", wr_addr, e_wr_addr);
      chk("wr_data", wr_data, e_wr_data);
    end
    chk("mac_valid", mac_valid, e_mv);
    chk("mac_last", mac_last, e_ml);
    if (e_mv || e_rst) chk("mac_x", mac_x, e_mx);
    if (e_mv && !PRE) chk("rd_data", rd_data, e_w);
    chk("loaded", loaded, exp_loaded);
  endtask

  task automatic idle();
    cfg_valid = 0; cfg_layer = '0; cfg_neuron = '0; cfg_data = '0;
    in_valid = 0; in_data = '0;
  endtask

  task automatic cfgw(input int layer, input int neuron, input logic [DATA_WIDTH-1:0] d);
    idle();
    cfg_valid = 1; cfg_layer = layer; cfg_neuron = neuron; cfg_data = d;
    cycle();
  endtask

  task automatic inw(input logic [DATA_WIDTH-1:0] x);
    idle();
    in_valid = 1; in_data = x;
    cycle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    cycle();
    cycle();
    rst_n = 1;
`ifndef WSEQ_PRETRAINED_EN
    inw(16'h0055);
    cfgw(1, 0, 16'h0011);
    cfgw(1, 1, 16'h00AA);
    cfgw(1, 0, 16'h0022);
    cfgw(1, 0, 16'h0033);
    idle(); cycle(); cycle();
    for (int x = 1; x <= 6; x++) inw(DATA_WIDTH'(x));
    inw(16'd7);
    idle(); cycle(); cycle();
    inw(16'd8);
    inw(16'd9);
    cfgw(1, 0, 16'hBEEF);
    inw(16'd10);
    inw(16'd11);
    rst_n = 0; idle(); cycle();
    rst_n = 1;
    inw(16'd12);
    for (int i = 0; i < NUM_WEIGHT; i++) cfgw(1, 0, DATA_WIDTH'($urandom));
    idle(); cycle();
    for (int i = 0; i < 4; i++) inw(DATA_WIDTH'($urandom));
`else
    for (int i = 0; i < 8; i++) begin
      idle();
      cfg_valid = 1; cfg_layer = 1; cfg_neuron = 0; cfg_data = DATA_WIDTH'($urandom);
      in_valid = 1; in_data = DATA_WIDTH'(i + 1);
      cycle();
    end
`endif
    repeat (1500) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_layer  = $urandom_range(0, 1);
      cfg_neuron = $urandom_range(0, 1);
      cfg_data   = DATA_WIDTH'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = DATA_WIDTH'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
